// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, reset PC and fetch-state encoding
package cpu_pkg;

  localparam int          CPU_DATA_W   = 32;
  localparam int          CPU_ADDR_W   = 6;
  localparam logic [31:0] CPU_RESET_PC = 32'd0;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_WAIT  = 2'd1,
    FS_LATCH = 2'd2
  } fstate_t;

endpackage

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, IR and memory-wait FSM
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = CPU_ADDR_W,
  parameter int          DATA_W   = CPU_DATA_W,
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter int          MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic              pc_ld,
  input  logic [31:0]       pc_ld_val,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_dout,
  output logic [DATA_W-1:0] instruction,
  output logic              ir_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_next,
  output logic              busy,
  output logic              ld_err,
  output logic [1:0]        fstate
);

  fstate_t           state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              ld_err_q, ld_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FS_IDLE;
      cnt_q    <= 3'd0;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      valid_q  <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      ld_err_q <= ld_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    valid_d  = 1'b0;
    ld_err_d = ld_err_q;

    // A PC load outside IDLE is dropped but flagged so control bugs stay visible
    if (pc_ld && (state_q != FS_IDLE)) begin
      ld_err_d = 1'b1;
    end

    case (state_q)
      FS_IDLE: begin
        if (pc_ld) begin
          pc_d = pc_ld_val;
        end else if (fetch_req) begin
          state_d = FS_WAIT;
          cnt_d   = 3'(MEM_LAT - 1);
        end
      end
      FS_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = FS_LATCH;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      FS_LATCH: begin
        if (!stall) begin
          ir_d    = imem_dout;
          pc_d    = pc_q + 32'd1;
          valid_d = 1'b1;
          state_d = FS_IDLE;
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  assign imem_addr   = pc_q[ADDR_W-1:0];
  assign instruction = ir_q;
  assign ir_valid    = valid_q;
  assign pc          = pc_q;
  assign pc_next     = pc_q + 32'd1;
  assign busy        = (state_q != FS_IDLE);
  assign ld_err      = ld_err_q;
  assign fstate      = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit at MEM_LAT 1 and 3
module tb_ifetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, fetch_req, stall, pc_ld;
  logic [31:0] pc_ld_val;
  logic [5:0]  addr_w [2];
  logic [31:0] ir_w [2], pc_w [2], pcn_w [2];
  logic        vld_w [2], busy_w [2], err_w [2];
  logic [1:0]  fs_w [2];
  logic [31:0] dout1, d3a, d3b, dout3;
  logic [31:0] mem [64];

  int vectors = 0;
  int miscompares = 0;

  ifetch_unit #(.ADDR_W(6), .DATA_W(32), .RESET_PC(32'd0), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .stall(stall), .pc_ld(pc_ld),
    .pc_ld_val(pc_ld_val), .imem_addr(addr_w[0]), .imem_dout(dout1),
    .instruction(ir_w[0]), .ir_valid(vld_w[0]), .pc(pc_w[0]), .pc_next(pcn_w[0]),
    .busy(busy_w[0]), .ld_err(err_w[0]), .fstate(fs_w[0]));

  ifetch_unit #(.ADDR_W(6), .DATA_W(32), .RESET_PC(32'd0), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .stall(stall), .pc_ld(pc_ld),
    .pc_ld_val(pc_ld_val), .imem_addr(addr_w[1]), .imem_dout(dout3),
    .instruction(ir_w[1]), .ir_valid(vld_w[1]), .pc(pc_w[1]), .pc_next(pcn_w[1]),
    .busy(busy_w[1]), .ld_err(err_w[1]), .fstate(fs_w[1]));

  // Synchronous memories with 1 and 3 edges of read latency
  always @(posedge clk) begin
    dout1 <= mem[addr_w[0]];
    d3a   <= mem[addr_w[1]];
    d3b   <= d3a;
    dout3 <= d3b;
  end

  // Transaction-level reference: a fetch accepted at edge E0 completes at the
  // first edge E >= E0+lat+1 that sees stall low
  logic [31:0] m_pc [2], m_ir [2];
  logic        m_busy [2], m_vld [2], m_err [2];
  int          m_acc [2];
  int          edge_n = 0;

  function automatic int lat(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] exp_fs(int k);
    if (!m_busy[k]) return 2'd0;
    return ((edge_n - m_acc[k] - 1) < lat(k)) ? 2'd1 : 2'd2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pc[k] <= 32'd0; m_ir[k] <= 32'd0; m_busy[k] <= 1'b0;
        m_vld[k] <= 1'b0; m_err[k] <= 1'b0; m_acc[k] <= 0;
      end
    end else begin
      edge_n <= edge_n + 1;
      for (int k = 0; k < 2; k++) begin
        m_vld[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (pc_ld) m_pc[k] <= pc_ld_val;
          else if (fetch_req) begin
            m_busy[k] <= 1'b1;
            m_acc[k]  <= edge_n;
          end
        end else begin
          if (pc_ld) m_err[k] <= 1'b1;
          if ((edge_n - m_acc[k] >= lat(k) + 1) && !stall) begin
            m_ir[k]   <= mem[m_pc[k][5:0]];
            m_pc[k]   <= m_pc[k] + 32'd1;
            m_vld[k]  <= 1'b1;
            m_busy[k] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    fetch_req = 1'b0; pc_ld = 1'b0; stall = 1'b0;
    for (int i = 0; i < 20 && (m_busy[0] || m_busy[1]); i++) tick();
    if (m_busy[0] || m_busy[1]) begin
      vectors++; miscompares++;
      $display("FAIL settle_timeout: model still busy after 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_req = 1'b0; stall = 1'b0; pc_ld = 1'b0; pc_ld_val = 32'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (fs_w[k] !== 2'd0) begin miscompares++; $display("FAIL reset_fstate[%0d]: got %0d want 0", k, fs_w[k]); end
      vectors++; if (pc_w[k] !== 32'd0) begin miscompares++; $display("FAIL reset_pc[%0d]: got %0h want 0", k, pc_w[k]); end
      vectors++; if (pcn_w[k] !== 32'd1) begin miscompares++; $display("FAIL reset_pc_next[%0d]: got %0h want 1", k, pcn_w[k]); end
      vectors++; if (ir_w[k] !== 32'd0) begin miscompares++; $display("FAIL reset_ir[%0d]: got %0h want 0", k, ir_w[k]); end
      vectors++; if ({vld_w[k], busy_w[k], err_w[k]} !== 3'b000) begin miscompares++; $display("FAIL reset_flags[%0d]: got %b want 000", k, {vld_w[k], busy_w[k], err_w[k]}); end
    end
  endtask

  task automatic test_basic_fetch();
    logic [1:0] want_fs [4];
    logic       want_v [4];
    want_fs = '{2'd1, 2'd2, 2'd0, 2'd0};
    want_v  = '{1'b0, 1'b0, 1'b1, 1'b0};
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++; if (fs_w[0] !== want_fs[c]) begin miscompares++; $display("FAIL basic_fstate_e%0d: got %0d want %0d", c, fs_w[0], want_fs[c]); end
      vectors++; if (vld_w[0] !== want_v[c]) begin miscompares++; $display("FAIL basic_valid_e%0d: got %b want %b", c, vld_w[0], want_v[c]); end
      if (c < 2) begin
        vectors++; if (addr_w[0] !== 6'd0) begin miscompares++; $display("FAIL basic_addr_e%0d: got %0d want 0", c, addr_w[0]); end
      end
      if (c < 3) tick();
    end
    vectors++; if (ir_w[0] !== 32'h2001_0005) begin miscompares++; $display("FAIL basic_ir: got %h want 20010005", ir_w[0]); end
    vectors++; if (pc_w[0] !== 32'd1) begin miscompares++; $display("FAIL basic_pc: got %0d want 1", pc_w[0]); end
    settle(); tick();
  endtask

  task automatic test_pc_load();
    pc_ld = 1'b1; pc_ld_val = 32'd10;
    tick();
    pc_ld = 1'b0; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    vectors++; if (addr_w[0] !== 6'd10) begin miscompares++; $display("FAIL pcld_addr: got %0d want 10", addr_w[0]); end
    settle(); tick();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (ir_w[k] !== 32'hAC22_0004) begin miscompares++; $display("FAIL pcld_ir[%0d]: got %h want ac220004", k, ir_w[k]); end
      vectors++; if (pc_w[k] !== 32'd11) begin miscompares++; $display("FAIL pcld_pc[%0d]: got %0d want 11", k, pc_w[k]); end
      vectors++; if (err_w[k] !== 1'b0) begin miscompares++; $display("FAIL pcld_err[%0d]: got %b want 0", k, err_w[k]); end
    end
  endtask

  task automatic test_ld_and_fetch_same_cycle();
    pc_ld = 1'b1; pc_ld_val = 32'd20; fetch_req = 1'b1;
    tick();
    pc_ld = 1'b0; fetch_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 2; k++) begin
        vectors++; if (pc_w[k] !== 32'd20) begin miscompares++; $display("FAIL ldfetch_pc[%0d]: got %0d want 20", k, pc_w[k]); end
        vectors++; if ({fs_w[k], vld_w[k]} !== 3'b000) begin miscompares++; $display("FAIL ldfetch_idle[%0d]: got fs=%0d v=%b want fs=0 v=0", k, fs_w[k], vld_w[k]); end
      end
      tick();
    end
    fetch_req = 1'b1;
    tick();
    settle(); tick();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (ir_w[k] !== mem[20]) begin miscompares++; $display("FAIL ldfetch_ir[%0d]: got %h want %h", k, ir_w[k], mem[20]); end
      vectors++; if (pc_w[k] !== 32'd21) begin miscompares++; $display("FAIL ldfetch_pc2[%0d]: got %0d want 21", k, pc_w[k]); end
    end
  endtask

  task automatic test_stall();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    stall = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      tick();
      vectors++; if ({fs_w[0], vld_w[0]} !== 3'b100) begin miscompares++; $display("FAIL stall_hold_e%0d: got fs=%0d v=%b want fs=2 v=0", c, fs_w[0], vld_w[0]); end
      vectors++; if (ir_w[0] !== mem[20] || pc_w[0] !== 32'd21) begin miscompares++; $display("FAIL stall_regs_e%0d: got ir=%h pc=%0d want ir=%h pc=21", c, ir_w[0], pc_w[0], mem[20]); end
    end
    stall = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (vld_w[k] !== 1'b1) begin miscompares++; $display("FAIL stall_capture_e5[%0d]: got v=%b want 1", k, vld_w[k]); end
      vectors++; if (ir_w[k] !== mem[21] || pc_w[k] !== 32'd22) begin miscompares++; $display("FAIL stall_result[%0d]: got ir=%h pc=%0d want ir=%h pc=22", k, ir_w[k], pc_w[k], mem[21]); end
    end
    settle(); tick();
  endtask

  task automatic test_ld_err_and_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; pc_ld = 1'b1; pc_ld_val = 32'd33;
    tick();
    pc_ld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++; if (err_w[k] !== 1'b1) begin miscompares++; $display("FAIL lderr_set[%0d]: got %b want 1", k, err_w[k]); end
      vectors++; if (pc_w[k] !== 32'd22) begin miscompares++; $display("FAIL lderr_pc[%0d]: got %0d want 22", k, pc_w[k]); end
    end
    settle(); tick();
    fetch_req = 1'b1; tick(); settle(); tick();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (err_w[k] !== 1'b1 || pc_w[k] !== 32'd24) begin miscompares++; $display("FAIL lderr_sticky[%0d]: got err=%b pc=%0d want err=1 pc=24", k, err_w[k], pc_w[k]); end
    end
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++; if ({fs_w[k], vld_w[k], err_w[k]} !== 4'b0000) begin miscompares++; $display("FAIL midreset_state[%0d]: got fs=%0d v=%b err=%b want 0/0/0", k, fs_w[k], vld_w[k], err_w[k]); end
      vectors++; if (pc_w[k] !== 32'd0 || ir_w[k] !== 32'd0) begin miscompares++; $display("FAIL midreset_regs[%0d]: got pc=%0d ir=%h want 0/0", k, pc_w[k], ir_w[k]); end
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++; if (vld_w[0] !== 1'b0 || vld_w[1] !== 1'b0) begin miscompares++; $display("FAIL midreset_novalid_c%0d: got %b%b want 00", c, vld_w[0], vld_w[1]); end
    end
  endtask

  task automatic test_wrap_and_latency();
    pc_ld = 1'b1; pc_ld_val = 32'd63;
    tick();
    pc_ld = 1'b0;
    vectors++; if (addr_w[0] !== 6'd63) begin miscompares++; $display("FAIL wrap_addr63: got %0d want 63", addr_w[0]); end
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++; if (vld_w[1] !== (c == 4)) begin miscompares++; $display("FAIL lat3_valid_e%0d: got %b want %b", c, vld_w[1], (c == 4)); end
      if (c == 2) begin
        vectors++; if (vld_w[0] !== 1'b1 || pc_w[0] !== 32'd64 || ir_w[0] !== mem[63]) begin miscompares++; $display("FAIL wrap_first: got v=%b pc=%0d ir=%h want 1/64/%h", vld_w[0], pc_w[0], ir_w[0], mem[63]); end
      end
    end
    vectors++; if (pc_w[1] !== 32'd64 || ir_w[1] !== mem[63]) begin miscompares++; $display("FAIL lat3_result: got pc=%0d ir=%h want 64/%h", pc_w[1], ir_w[1], mem[63]); end
    tick();
    vectors++; if (addr_w[0] !== 6'd0 || addr_w[1] !== 6'd0) begin miscompares++; $display("FAIL wrap_addr0: got %0d/%0d want 0/0", addr_w[0], addr_w[1]); end
    fetch_req = 1'b1; tick(); settle(); tick();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (pc_w[k] !== 32'd65 || ir_w[k] !== mem[0]) begin miscompares++; $display("FAIL wrap_second[%0d]: got pc=%0d ir=%h want 65/%h", k, pc_w[k], ir_w[k], mem[0]); end
    end
  endtask

  task automatic test_random();
    int prev_v [2];
    prev_v = '{0, 0};
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int c = 0; c < 400; c++) begin
      fetch_req = ($urandom_range(0, 1) == 1);
      pc_ld     = ($urandom_range(0, 7) == 0);
      pc_ld_val = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'd0) + $urandom_range(0, 200);
      stall     = ($urandom_range(0, 2) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (fs_w[k] !== exp_fs(k) || vld_w[k] !== m_vld[k] || ir_w[k] !== m_ir[k] ||
            pc_w[k] !== m_pc[k] || pcn_w[k] !== m_pc[k] + 32'd1 || err_w[k] !== m_err[k] ||
            addr_w[k] !== m_pc[k][5:0] || busy_w[k] !== m_busy[k]) begin
          miscompares++;
          $display("FAIL random_c%0d[%0d]: got fs=%0d v=%b ir=%h pc=%h err=%b busy=%b want fs=%0d v=%b ir=%h pc=%h err=%b busy=%b",
                   c, k, fs_w[k], vld_w[k], ir_w[k], pc_w[k], err_w[k], busy_w[k],
                   exp_fs(k), m_vld[k], m_ir[k], m_pc[k], m_err[k], m_busy[k]);
        end
        vectors++;
        if (prev_v[k] == 1 && vld_w[k] === 1'b1) begin
          miscompares++;
          $display("FAIL random_double_pulse_c%0d[%0d]: got consecutive ir_valid want isolated", c, k);
        end
        prev_v[k] = (vld_w[k] === 1'b1) ? 1 : 0;
      end
    end
    settle(); tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'h2001_0005;
    mem[10] = 32'hAC22_0004;
    mem[20] = 32'h1234_5678;
    mem[21] = 32'h8C43_0010;
    mem[63] = 32'hDEAD_BEEF;
    test_reset();
    test_basic_fetch();
    test_pc_load();
    test_ld_and_fetch_same_cycle();
    test_stall();
    test_ld_err_and_reset();
    test_wrap_and_latency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch stage of the multi-cycle CPU, directly upstream of the control FSM. Owns the program counter and instruction register. On request from control, it reads the synchronous instruction memory and presents a stable instruction with a one-cycle valid pulse. It also accepts branch/jump PC loads from control.

Parameters:
ADDR_W, 6, instruction-memory word-address width; imem_addr = pc[ADDR_W-1:0]
DATA_W, 32, instruction width
RESET_PC, 0, PC value after reset (word address)
MEM_LAT, 1, instruction-memory read latency in clock edges; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  control requests a fetch; sampled only in IDLE
stall  in  1  holds LATCH state without capturing
pc_ld  in  1  load PC from pc_ld_val; sampled only in IDLE
pc_ld_val  in  32  branch/jump target, word address
imem_addr  out  ADDR_W  instruction-memory read address
imem_dout  in  DATA_W  instruction-memory read data
instruction  out  DATA_W  instruction register (IR)
ir_valid  out  1  one-cycle pulse when IR is updated
pc  out  32  current PC, word address
pc_next  out  32  pc + 1, combinational
busy  out  1  high when state != IDLE
ld_err  out  1  sticky; set when pc_ld is seen while busy
fstate  out  2  FSM state for debug: IDLE=0, WAIT=1, LATCH=2

Behaviour:
- Reset (async, rst_n low) forces: state=IDLE, pc=RESET_PC, instruction=0, ir_valid=0, ld_err=0, wait counter=0. Reset mid-fetch abandons the fetch; no ir_valid is produced.
- imem_addr is combinational: imem_addr = pc[ADDR_W-1:0] at all times. The PC changes only at LATCH capture or on pc_ld in IDLE, so the address is stable throughout a fetch.
- IDLE:
  - pc_ld=1: pc <= pc_ld_val and stay in IDLE. A fetch_req in the same cycle is ignored; control must reissue it.
  - Otherwise, fetch_req=1: go to WAIT with cnt <= MEM_LAT-1.
- WAIT:
  - cnt==0: go to LATCH.
  - Otherwise: cnt <= cnt-1.
- LATCH:
  - stall=1: stay in LATCH; IR and pc are unchanged.
  - stall=0: instruction <= imem_dout, pc <= pc+1, ir_valid <= 1 for exactly one cycle, go to IDLE.
- Latency: fetch_req accepted at edge E0. With no stall, IR loads at edge E0+MEM_LAT+1, and ir_valid is high during the following cycle. Each stall cycle adds one cycle.
- fetch_req while busy: ignored (it is not queued).
- pc_ld while busy: ignored, and ld_err <= 1. ld_err clears only on reset.
- PC arithmetic: 32-bit modulo 2^32; pc_next = pc+1, truncated. The memory address wraps at 2^ADDR_W words (pc=63 reads word 63, and the next fetch reads word 0 when ADDR_W=6).
- instruction holds its value between fetches.
- ir_valid is never high in consecutive cycles. Minimum spacing between pulses is MEM_LAT+2 cycles.

Decomposition:
- Shared package cpu_pkg:
  - fetch state encoding constants FS_IDLE/FS_WAIT/FS_LATCH (2 bits)
  - DATA_W and ADDR_W defaults, shared with the register file, ALU, and data memory
  - RESET_PC
- No sub-module is needed. The wait counter is a small in-module register (3 bits covers MEM_LAT up to 4). The FSM, PC register, and IR stay in one module.

Test Plan:
- Reset, then fetch_req pulse at E0 with a memory model (MEM_LAT=1, mem[0]=32'h2001_0005) -> imem_addr=0; instruction=32'h2001_0005 after E2; ir_valid high for one cycle; pc=1; fstate sequence 0,1,2,0.
- pc_ld=1 with pc_ld_val=32'd10 in IDLE, then fetch_req (mem[10]=32'hAC22_0004) -> imem_addr=10; instruction=32'hAC22_0004; pc=11; ld_err=0.
- fetch_req and pc_ld=1 (val=20) in the same IDLE cycle -> pc=20, state stays IDLE, no ir_valid; a subsequent fetch_req reads mem[20].
- stall held high for 3 cycles in LATCH -> IR unchanged and pc unchanged during the stall; capture occurs on the first edge with stall=0, giving a total latency of 5 edges from accept.
- pc_ld=1 during WAIT -> pc unaffected, ld_err=1 and stays 1 through later fetches until rst_n is asserted; rst_n low mid-WAIT -> fstate=0, pc=RESET_PC, instruction=0, no ir_valid.
- pc_ld_val=63 with ADDR_W=6, then two fetches -> first imem_addr=63, pc=64; second imem_addr=0, pc=65. Repeat the fetch with MEM_LAT=3 -> IR loads at E0+4.
